uart_tx_fifo: RTL
=================

# uart_tx_fifo

Transmit-side byte buffer and loader placed directly upstream of the UART transmitter. Accepts bytes from the softcore's write port at full clock rate, stores up to DEPTH of them, and feeds the UART one byte at a time through its `ld_tx_data` / `tx_data` / `tx_empty` handshake. The UART's transmit path can then be driven without the processor polling `tx_empty`.

## Interface

Parameters:
- `DEPTH`, default 16: number of byte slots; must be a power of two, at least 2.
- `ADDR_W`, default 4: pointer width; must equal log2(DEPTH).

Ports (clock and reset first):
- `txclk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high.
- `wr_en`, input, 1: push `wr_data` this cycle.
- `wr_data`, input, 8: byte to enqueue.
- `full`, output, 1: high when count == DEPTH.
- `count`, output, ADDR_W+1: bytes currently stored.
- `overflow`, output, 1: sticky; set when a push is dropped.
- `clr_ovf`, input, 1: clears `overflow`.
- `en`, input, 1: allows new loads into the UART; also drives `tx_enable`.
- `tx_enable`, output, 1: equals `en`, combinational.
- `ld_tx_data`, output, 1: one-cycle load strobe to the UART.
- `tx_data`, output, 8: byte presented to the UART; registered.
- `tx_empty`, input, 1: UART transmitter idle flag.

## Operation

Reset values: `count`=0, `full`=0, `overflow`=0, `ld_tx_data`=0, `tx_data`=8'h00, FSM in IDLE. Pointers are also 0.

FIFO:
- A push is accepted when `wr_en` is high and either `count` < DEPTH, or a pop happens in the same cycle.
- A push is dropped when `wr_en` is high, `full` is high and no pop happens that cycle. A dropped push sets `overflow`.
- If `clr_ovf` and a dropped push occur in the same cycle, `overflow` ends set.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave `count` unchanged.
- A pop occurs only on the FSM's LOAD transition.

FSM states:
- IDLE:
  - Stays in IDLE while `count`==0, `en`==0, or `tx_empty`==0.
  - Otherwise it pops the head byte into `tx_data`, registers `ld_tx_data`=1 and moves to LOAD.
- LOAD:
  - `ld_tx_data` is high for exactly this one cycle, then cleared.
  - Moves to WAIT_BUSY.
- WAIT_BUSY:
  - Waits for `tx_empty`==0, meaning the UART accepted the byte.
  - Moves to WAIT_DONE when it sees that.
- WAIT_DONE:
  - Waits for `tx_empty`==1, meaning the frame is finished.
  - Moves to IDLE.

Handshake rules:
- `tx_data` stays stable from the start of LOAD until the next LOAD.
- `en` is sampled only in IDLE. Dropping `en` never aborts a byte already loaded.
- A write into an empty FIFO while the UART is idle still goes through the FIFO. There is no bypass path.

Reset mid-operation:
- All stored bytes are discarded and the FSM returns to IDLE.
- `ld_tx_data` is 0 on the cycle after reset is asserted.
- A UART frame already in progress is not affected.

## Timing

- Write latency: a push captured at edge N is reflected in `count` after edge N.
- Load latency, FIFO empty and UART idle with `en`=1:
  - The push is captured at edge N.
  - IDLE evaluates during the cycle after edge N and registers the LOAD transition at edge N+1.
  - `ld_tx_data` is high from edge N+1 to edge N+2.
- Back-to-back bytes: the next `ld_tx_data` comes no sooner than one cycle after `tx_empty` rises. Minimum spacing is LOAD + WAIT_BUSY + WAIT_DONE + IDLE.
- `full` and `count` are registered and change only on clock edges.

## Structure

- Shared package `uart_pkg`:
  - FSM state encoding: IDLE=2'd0, LOAD=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
  - Default DEPTH.
  - Byte width constant: 8.
- Sub-module `fifo_sync_mem`:
  - DEPTH×8 storage array with one write port and one read address.
  - Registered write, combinational read of the head.
  - Pointer, count and flag logic stay in `uart_tx_fifo`.

## Test plan

- Reset, then push 8'hA5 with `tx_empty`=1 and `en`=1:
  - `ld_tx_data` pulses for one cycle, one cycle after the push edge.
  - `tx_data`=8'hA5 and `count` returns to 0.
- Push 3 bytes (8'h01, 8'h02, 8'h03) while the UART model holds `tx_empty` low for 10 cycles per byte:
  - Loads occur in order 01, 02, 03.
  - Each load comes after `tx_empty` rises.
  - Exactly 3 `ld_tx_data` pulses.
- Hold `en`=0 and push 16 bytes:
  - `full`=1 and `count`=16.
  - A 17th push sets `overflow` and `count` stays 16.
  - `clr_ovf` clears `overflow`.
- With the FIFO full, push in the same cycle as a LOAD pop:
  - The push is accepted, `count` stays 16 and `overflow` stays 0.
  - Readback order includes the new byte last, confirming pointer wrap.
- Assert `reset` during WAIT_DONE with 5 bytes queued:
  - The next cycle shows `count`=0, `ld_tx_data`=0, `tx_data`=8'h00.
  - No further loads occur after `tx_empty` rises.
- Drop `en` while in WAIT_BUSY:
  - The current byte completes.
  - No new load occurs until `en`=1 again, with the queued byte then loaded from IDLE.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: byte width, default
// depth and the loader FSM state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the processor write port and the UART load handshake.
//   slave  : buffer side (uart_tx_fifo)
//   master : environment side (processor write port + UART transmitter)
// Signals: wr_en/wr_data/clr_ovf/en/tx_empty flow into the buffer;
//          full/count/overflow/tx_enable/ld_tx_data/tx_data flow out.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  import uart_pkg::*;

  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_ovf;
  logic              en;
  logic              tx_enable;
  logic              ld_tx_data;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_empty;

  modport slave (
    input  wr_en, wr_data, clr_ovf, en, tx_empty,
    output full, count, overflow, tx_enable, ld_tx_data, tx_data
  );

  modport master (
    output wr_en, wr_data, clr_ovf, en, tx_empty,
    input  full, count, overflow, tx_enable, ld_tx_data, tx_data
  );

endinterface

// File: rtl/uart_tx_fifo_mem.sv
// fifo_sync_mem: DEPTH x BYTE_W storage with one registered write port and
// a combinational read of the addressed slot.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_sync_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. Bytes pushed on
// the write port are queued and handed to the UART one at a time using the
// ld_tx_data / tx_data / tx_empty handshake.
// Ports: txclk (clock), reset (sync, active-high), bus (uart_tx_fifo_if.slave).
// Parameters: DEPTH (power of two, >= 2), ADDR_W = log2(DEPTH).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = 4
) (
  input  logic           txclk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int unsigned     CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  tx_state_e         state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              overflow_q;
  logic              ld_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [BYTE_W-1:0] head;

  logic full_w;
  logic pop;
  logic push_ok;
  logic push_drop;

  // A pop is the IDLE->LOAD transition itself; a push into a full FIFO is
  // still accepted when it coincides with that pop.
  always_comb begin
    full_w    = (count_q == DEPTH_CNT);
    pop       = (state == IDLE) && (count_q != '0) && bus.en && bus.tx_empty;
    push_ok   = bus.wr_en && (!full_w || pop);
    push_drop = bus.wr_en && !push_ok;
  end

  fifo_sync_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (txclk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge txclk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      // A drop in the same cycle as clr_ovf wins.
      if (push_drop)         overflow_q <= 1'b1;
      else if (bus.clr_ovf)  overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge txclk) begin
    if (reset) begin
      state     <= IDLE;
      ld_q      <= 1'b0;
      tx_data_q <= '0;
    end else begin
      ld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_q <= head;
            ld_q      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD:      state <= WAIT_BUSY;
        WAIT_BUSY: if (!bus.tx_empty) state <= WAIT_DONE;
        WAIT_DONE: if (bus.tx_empty)  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  assign bus.full       = full_w;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.tx_enable  = bus.en;
  assign bus.ld_tx_data = ld_q;
  assign bus.tx_data    = tx_data_q;

endmodule
